// File: rtl/box_draw_arbiter.sv
// Three-requester round-robin arbiter in front of a single box drawer.
// The winner's coordinates are latched for the whole draw; go/ack are one-cycle pulses.
module box_draw_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [23:0] req_x,
  input  logic [20:0] req_y,
  input  logic [8:0]  req_clr,
  input  logic [17:0] req_scale,
  output logic [2:0]  ack,
  output logic        busy,
  output logic [7:0]  Xsym,
  output logic [6:0]  Ysym,
  output logic [2:0]  CLRsym,
  output logic [5:0]  Scalesym,
  output logic        go,
  input  logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  ptr;
  logic [1:0]  winner;
  logic [1:0]  p0;
  logic [1:0]  p1;
  logic [1:0]  p2;
  logic [1:0]  grant_idx;
  logic        grant_valid;
  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [2:0]  sel_clr;
  logic [5:0]  sel_scale;

  function automatic logic [1:0] next_mod3(input logic [1:0] v);
    case (v)
      2'd0:    next_mod3 = 2'd1;
      2'd1:    next_mod3 = 2'd2;
      default: next_mod3 = 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] v);
    case (v)
      2'd0:    onehot3 = 3'b001;
      2'd1:    onehot3 = 3'b010;
      default: onehot3 = 3'b100;
    endcase
  endfunction

  // Round-robin search order starting at ptr (3 aliases to 0).
  always_comb begin
    p0 = (ptr == 2'd3) ? 2'd0 : ptr;
    p1 = next_mod3(p0);
    p2 = next_mod3(p1);
    grant_valid = 1'b1;
    grant_idx   = p0;
    if (req[p0]) begin
      grant_idx = p0;
    end else if (req[p1]) begin
      grant_idx = p1;
    end else if (req[p2]) begin
      grant_idx = p2;
    end else begin
      grant_valid = 1'b0;
    end
  end

  // Field mux for the candidate winner.
  always_comb begin
    sel_x     = 8'd0;
    sel_y     = 7'd0;
    sel_clr   = 3'd0;
    sel_scale = 6'd0;
    case (grant_idx)
      2'd0: begin
        sel_x = req_x[7:0];   sel_y = req_y[6:0];
        sel_clr = req_clr[2:0]; sel_scale = req_scale[5:0];
      end
      2'd1: begin
        sel_x = req_x[15:8];  sel_y = req_y[13:7];
        sel_clr = req_clr[5:3]; sel_scale = req_scale[11:6];
      end
      default: begin
        sel_x = req_x[23:16]; sel_y = req_y[20:14];
        sel_clr = req_clr[8:6]; sel_scale = req_scale[17:12];
      end
    endcase
  end

  // Next-state logic; done is only looked at in WAIT so a stale done cannot end a draw.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        if (done) begin
          state_next = ACK;
        end else begin
          state_next = WAIT;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, pointer, latched fields and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      winner   <= 2'd0;
      go       <= 1'b0;
      ack      <= 3'b000;
      busy     <= 1'b0;
      Xsym     <= 8'd0;
      Ysym     <= 7'd0;
      CLRsym   <= 3'd0;
      Scalesym <= 6'd0;
    end else begin
      state <= state_next;
      go    <= (state_next == START);
      busy  <= (state_next != IDLE);
      ack   <= (state_next == ACK) ? onehot3(winner) : 3'b000;
      if (state == IDLE && grant_valid) begin
        winner   <= grant_idx;
        Xsym     <= sel_x;
        Ysym     <= sel_y;
        CLRsym   <= sel_clr;
        Scalesym <= sel_scale;
      end
      if (state == ACK) begin
        ptr <= next_mod3(winner);
      end
    end
  end

endmodule

// File: doc/box_draw_arbiter.md
BOX_DRAW_ARBITER -- requirements
Module: box_draw_arbiter

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock); reset (input, 1, synchronous active-high reset).
REQ-002 The block SHALL have: req (input, 3, per-requester draw request; level, held until ack).
REQ-003 The block SHALL have: req_x (input, 24, requester i X at bits [8i+7:8i]).
REQ-004 The block SHALL have: req_y (input, 21, requester i Y at bits [7i+6:7i]).
REQ-005 The block SHALL have: req_clr (input, 9, requester i colour at bits [3i+2:3i]).
REQ-006 The block SHALL have: req_scale (input, 18, requester i scale at bits [6i+5:6i]).
REQ-007 The block SHALL have: ack (output, 3, one-cycle pulse on the bit of the requester whose box finished).
REQ-008 The block SHALL have: busy (output, 1, high in every state except IDLE).
REQ-009 The block SHALL have: Xsym (output, 8, X to box drawer).
REQ-010 The block SHALL have: Ysym (output, 7, Y to box drawer).
REQ-011 The block SHALL have: CLRsym (output, 3, colour to box drawer).
REQ-012 The block SHALL have: Scalesym (output, 6, scale to box drawer).
REQ-013 The block SHALL have: go (output, 1, start pulse to box drawer).
REQ-014 The block SHALL have: done (input, 1, completion from box drawer).

Function
REQ-015 The FSM SHALL have exactly the states IDLE, START, WAIT and ACK.
REQ-016 In IDLE with req==0, the FSM SHALL stay in IDLE with no output change.
REQ-017 In IDLE with any req bit set, the FSM SHALL, on that edge: pick the winner round-robin; latch the winner's index and its X/Y/CLR/Scale into Xsym/Ysym/CLRsym/Scalesym; go to START.
REQ-018 Round-robin SHALL search from the 2-bit pointer ptr upward, modulo 3, and take the first set req bit.
REQ-019 A ptr value of 3 SHALL be treated as 0.
REQ-020 In START, go SHALL be 1 for exactly one cycle, and the next state SHALL be WAIT.
REQ-021 done SHALL be ignored in START, so a stale done from a previous box cannot end the new draw.
REQ-022 In WAIT, go SHALL be 0; the FSM SHALL stay in WAIT while done==0 and move to ACK on the first cycle done==1.
REQ-023 No timeout SHALL exist in WAIT.
REQ-024 In ACK, ack[winner] SHALL be 1 for exactly one cycle with all other ack bits 0.
REQ-025 On leaving ACK, ptr SHALL become (winner+1) mod 3, and the next state SHALL be IDLE.
REQ-026 Latency SHALL be: req sampled in IDLE at edge N gives go high during cycle N+1; done sampled high at edge M gives ack high during cycle M+1; the next go is no earlier than cycle M+3.
REQ-027 Xsym/Ysym/CLRsym/Scalesym SHALL stay stable from the latch edge through ACK, whatever req_* does.
REQ-028 After ACK, the outputs SHALL hold their last values in IDLE until the next latch.
REQ-029 Deasserting the winner's req during START/WAIT SHALL NOT abort the draw; ack SHALL still pulse.
REQ-030 req bits that rise while busy SHALL wait; they are arbitrated only in IDLE.
REQ-031 With all three req bits held high, grants SHALL rotate 0,1,2,0,...; no requester gets a second grant before each other active requester gets one.
REQ-032 The 7-bit Y and 6-bit Scale fields SHALL pass through unmodified; the block does no arithmetic on coordinates.

Reset
REQ-033 While reset==1 at a rising edge: state SHALL go to IDLE; ptr to 0; go, ack and busy to 0; Xsym, Ysym, CLRsym and Scalesym to 0.
REQ-034 Reset SHALL have priority over every transition, including mid-WAIT.
REQ-035 A draw in progress SHALL be abandoned without ack.
REQ-036 A done arriving after a mid-operation reset, while in IDLE, SHALL be ignored.
REQ-037 The first cycle after reset deasserts SHALL be an IDLE cycle, and arbitration from it SHALL use ptr=0.

Verification
REQ-038 Single request: reset, then req=3'b010 with X=40,Y=30,CLR=4,Scale=5 -> go pulses one cycle later with Xsym=40,Ysym=30,CLRsym=4,Scalesym=5; done after 20 cycles -> ack=3'b010 one cycle later; busy falls with ack.
REQ-039 Fairness: req=3'b111 held, done returned 4 cycles after each go -> ack order 001,010,100,001; each ack exactly one cycle wide.
REQ-040 Stale done: done held high across START -> go still pulses once; ACK is entered only from WAIT, one cycle after go.
REQ-041 Input stability: req_x[7:0] changed 10 times during WAIT -> Xsym keeps the latched value until the next grant.
REQ-042 Reset mid-WAIT: reset for 1 cycle during WAIT, then done=1 -> no ack pulse; go=0, busy=0, all sym outputs 0; next grant with req=3'b110 goes to requester 1 (ptr=0).
REQ-043 Withdrawn request: winner's req dropped one cycle after go -> draw completes and ack still pulses for that requester.
